// File: rtl/m68k_bus_responder_pkg.sv
// Shared definitions for the 68000 bus responder: region indices, FSM encoding
// and the value driven onto the data bus when nothing answers.
package m68k_bus_responder_pkg;

  localparam int SRC_PROG_ROM   = 0;
  localparam int SRC_RAM        = 1;
  localparam int SRC_SHARED_RAM = 2;
  localparam int SRC_PALETTE    = 3;
  localparam int SRC_IO         = 4;
  localparam int SRC_SOUND      = 5;
  localparam int SRC_VIDEO      = 6;
  localparam int SRC_AUX        = 7;

  localparam logic [15:0] OPEN_BUS_DEFAULT = 16'hFFFF;
  localparam int          CNT_W            = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } bus_state_t;

  // Increment that parks at lim instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] lim);
    return (v >= lim) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/m68k_bus_responder_prio_enc.sv
// Lowest-set-bit priority encoder: index of the lowest asserted request plus
// a valid flag when any request is present.
module prio_enc_onehot #(
  parameter int N = 8,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         valid
);

  always_comb begin
    idx   = '0;
    valid = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/m68k_bus_responder.sv
// 68000 bus responder: captures the decoded region on AS, waits (fixed or
// handshake), returns DTACK with latched read data or issues a write strobe.
module m68k_bus_responder
  import m68k_bus_responder_pkg::*;
#(
  parameter int                 NUM_SRC    = 8,
  parameter int                 FIXED_WAIT = 2,
  parameter logic [NUM_SRC-1:0] HS_MASK    = NUM_SRC'(1 << SRC_PROG_ROM),
  parameter int                 TIMEOUT    = 255,
  parameter logic [15:0]        OPEN_BUS   = OPEN_BUS_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cpu_as_n,
  input  logic                   cpu_rw,
  input  logic                   cpu_uds_n,
  input  logic                   cpu_lds_n,
  input  logic [NUM_SRC-1:0]     src_sel,
  input  logic [NUM_SRC-1:0]     src_ready,
  input  logic [NUM_SRC*16-1:0]  src_dout,
  output logic [15:0]            cpu_din,
  output logic                   cpu_dtack_n,
  output logic [NUM_SRC-1:0]     src_rd_req,
  output logic [NUM_SRC-1:0]     src_wr_stb,
  output logic                   timeout_err,
  output logic                   busy
);

  localparam int                 IDX_W       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [CNT_W-1:0]   WAIT_LAST   = CNT_W'(FIXED_WAIT - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic [NUM_SRC-1:0] ONE         = NUM_SRC'(1);

  bus_state_t         state_reg, state_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic               mapped_reg, mapped_next;
  logic               read_reg, read_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [15:0]        din_reg, din_next;
  logic               dtack_n_reg, dtack_n_next;
  logic [NUM_SRC-1:0] rd_req_reg, rd_req_next;
  logic [NUM_SRC-1:0] wr_stb_reg, wr_stb_next;
  logic               terr_reg, terr_next;

  logic [IDX_W-1:0]   enc_idx;
  logic               enc_valid;
  logic [15:0]        dout_arr [NUM_SRC];
  logic [NUM_SRC-1:0] idx_onehot;
  logic [15:0]        sel_data;
  logic               sel_hs, sel_ready, slave_done, cycle_start;

  prio_enc_onehot #(.N(NUM_SRC), .W(IDX_W)) u_prio (
    .req   (src_sel),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_dout
    assign dout_arr[gi] = src_dout[16*gi +: 16];
  end

  // Everything below WAIT uses only what was captured in IDLE; live src_sel is ignored.
  assign idx_onehot  = ONE << idx_reg;
  assign sel_data    = dout_arr[idx_reg];
  assign sel_hs      = HS_MASK[idx_reg];
  assign sel_ready   = src_ready[idx_reg];
  assign slave_done  = sel_hs ? sel_ready : (cnt_reg == WAIT_LAST);
  assign cycle_start = !cpu_as_n && !(cpu_uds_n && cpu_lds_n);

  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    mapped_next  = mapped_reg;
    read_next    = read_reg;
    cnt_next     = cnt_reg;
    din_next     = din_reg;
    dtack_n_next = dtack_n_reg;
    rd_req_next  = '0;
    wr_stb_next  = '0;
    terr_next    = terr_reg;

    case (state_reg)
      IDLE: begin
        if (cycle_start) begin
          state_next  = WAIT;
          idx_next    = enc_idx;
          mapped_next = enc_valid;
          read_next   = cpu_rw;
          cnt_next    = '0;
          if (enc_valid && HS_MASK[enc_idx]) rd_req_next = ONE << enc_idx;
        end
      end
      WAIT: begin
        cnt_next = sat_inc(cnt_reg, TIMEOUT_CNT);
        if (cpu_as_n) begin
          state_next = IDLE;
        end else if (!mapped_reg) begin
          if (cnt_reg == WAIT_LAST) begin
            state_next   = ACK;
            dtack_n_next = 1'b0;
            if (read_reg) din_next = OPEN_BUS;
          end
        end else if (slave_done) begin
          state_next   = ACK;
          dtack_n_next = 1'b0;
          if (read_reg) din_next = sel_data;
          else          wr_stb_next = idx_onehot;
        end else if (cnt_reg == TIMEOUT_CNT) begin
          // Hung slave: the write is dropped, the CPU is released with open bus.
          state_next   = ACK;
          dtack_n_next = 1'b0;
          terr_next    = 1'b1;
          if (read_reg) din_next = OPEN_BUS;
        end else if (sel_hs) begin
          rd_req_next = idx_onehot;
        end
      end
      ACK: begin
        if (cpu_as_n) begin
          dtack_n_next = 1'b1;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      mapped_reg  <= 1'b0;
      read_reg    <= 1'b1;
      cnt_reg     <= '0;
      din_reg     <= 16'h0000;
      dtack_n_reg <= 1'b1;
      rd_req_reg  <= '0;
      wr_stb_reg  <= '0;
      terr_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      mapped_reg  <= mapped_next;
      read_reg    <= read_next;
      cnt_reg     <= cnt_next;
      din_reg     <= din_next;
      dtack_n_reg <= dtack_n_next;
      rd_req_reg  <= rd_req_next;
      wr_stb_reg  <= wr_stb_next;
      terr_reg    <= terr_next;
    end
  end

  assign cpu_din     = din_reg;
  assign cpu_dtack_n = dtack_n_reg;
  assign src_rd_req  = rd_req_reg;
  assign src_wr_stb  = wr_stb_reg;
  assign timeout_err = terr_reg;
  assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_m68k_bus_responder.sv
// Bench for m68k_bus_responder: each bus cycle is described as a timeline
// (capture edge, acknowledge edge, release edge) from which every output is derived.
module tb_m68k_bus_responder;

  localparam int          NUM_SRC    = 8;
  localparam int          FIXED_WAIT = 2;
  localparam int          TIMEOUT    = 255;
  localparam logic [7:0]  HS_MASK    = 8'h01;
  localparam logic [15:0] OPEN_BUS   = 16'hFFFF;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         cpu_as_n, cpu_rw, cpu_uds_n, cpu_lds_n;
  logic [7:0]   src_sel, src_ready;
  logic [127:0] src_dout;
  logic [15:0]  cpu_din;
  logic         cpu_dtack_n;
  logic [7:0]   src_rd_req, src_wr_stb;
  logic         timeout_err, busy;

  m68k_bus_responder #(
    .NUM_SRC(NUM_SRC), .FIXED_WAIT(FIXED_WAIT), .HS_MASK(HS_MASK),
    .TIMEOUT(TIMEOUT), .OPEN_BUS(OPEN_BUS)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cpu_as_n(cpu_as_n), .cpu_rw(cpu_rw),
    .cpu_uds_n(cpu_uds_n), .cpu_lds_n(cpu_lds_n), .src_sel(src_sel),
    .src_ready(src_ready), .src_dout(src_dout), .cpu_din(cpu_din),
    .cpu_dtack_n(cpu_dtack_n), .src_rd_req(src_rd_req), .src_wr_stb(src_wr_stb),
    .timeout_err(timeout_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared = 0;
  int mismatched = 0;

  // Current bus cycle, edges counted from the capture edge (k = 0).
  bit          tx_valid = 0;
  int          tx_cap, tx_ack, tx_rel, tx_end;
  bit          tx_abort, tx_read, tx_hs, tx_accept, tx_tmo;
  logic [7:0]  tx_oh;
  logic [15:0] tx_data;
  logic [15:0] model_din = 16'h0000;
  bit          model_terr = 0;
  int          first_dt, req_cycles, stb_cycles, stb_k;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  initial begin : compare_proc
    int k;
    bit in_tx, e_busy, e_dt;
    logic [7:0] e_req, e_stb;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
        model_din  = 16'h0000;
        model_terr = 0;
        tx_valid   = 0;
      end
      k      = cyc - tx_cap;
      in_tx  = tx_valid && (k >= 0);
      e_busy = in_tx && (k < tx_end);
      e_req  = (in_tx && tx_hs && k < tx_ack && k < tx_end) ? tx_oh : 8'h00;
      e_dt   = !(in_tx && !tx_abort && k >= tx_ack && k < tx_rel);
      e_stb  = (in_tx && !tx_abort && !tx_read && tx_accept && k == tx_ack) ? tx_oh : 8'h00;
      if (in_tx && !tx_abort && k == tx_ack) begin
        if (tx_read) model_din = tx_accept ? tx_data : OPEN_BUS;
        if (tx_tmo)  model_terr = 1;
      end
      chk("dtack_n", 16'(cpu_dtack_n), 16'(e_dt));
      chk("din", cpu_din, model_din);
      chk("rd_req", 16'(src_rd_req), 16'(e_req));
      chk("wr_stb", 16'(src_wr_stb), 16'(e_stb));
      chk("timeout_err", 16'(timeout_err), 16'(model_terr));
      chk("busy", 16'(busy), 16'(e_busy));
      if (in_tx) begin
        if (!cpu_dtack_n && first_dt < 0) first_dt = k;
        if (src_rd_req != 8'h00) req_cycles++;
        if (src_wr_stb != 8'h00) begin
          stb_cycles++;
          stb_k = k;
        end
      end
    end
  end

  // rdy_at: edge (k) at which ready is first sampled, 0 = never.
  // abort_at: edge at which AS is first seen high in WAIT, 0 = none.
  // rst_at: >= 0 asserts reset that many cycles into ACK.
  task automatic run_tx(input logic [7:0] sel, input bit rd, input logic uds, input logic lds,
                        input int rdy_at, input int abort_at, input int hold, input int gap,
                        input logic [127:0] dout, input int rst_at);
    int idx;
    bit mapped, rdy_on;
    @(negedge clk);
    mapped = (sel != 8'h00);
    idx = 0;
    for (int i = NUM_SRC - 1; i >= 0; i--) if (sel[i]) idx = i;
    tx_oh     = mapped ? (8'h01 << idx) : 8'h00;
    tx_hs     = mapped && HS_MASK[idx];
    tx_accept = mapped && (!tx_hs || (rdy_at >= 1 && rdy_at <= TIMEOUT + 1));
    tx_tmo    = tx_hs && !tx_accept;
    tx_ack    = tx_hs ? (tx_accept ? rdy_at : TIMEOUT + 1) : FIXED_WAIT;
    tx_abort  = (abort_at >= 1) && (abort_at <= tx_ack);
    tx_rel    = tx_ack + hold + 1;
    tx_end    = tx_abort ? abort_at : tx_rel;
    tx_read   = rd;
    tx_data   = dout[16*idx +: 16];
    tx_cap    = cyc + 1;
    tx_valid  = 1;
    first_dt = -1; req_cycles = 0; stb_cycles = 0; stb_k = -1;
    src_sel   = sel;
    src_dout  = dout;
    cpu_rw    = rd;
    cpu_uds_n = uds;
    cpu_lds_n = lds;
    src_ready = tx_hs ? 8'h00 : 8'($urandom);
    cpu_as_n  = 1'b0;
    for (int k = 0; k < tx_end; k++) begin
      @(negedge clk);
      src_sel = 8'($urandom);
      rdy_on  = tx_hs && rdy_at >= 1 && k >= rdy_at - 1;
      if (tx_hs) src_ready = (8'($urandom) & ~tx_oh) | (rdy_on ? tx_oh : 8'h00);
      else       src_ready = 8'($urandom);
      if (rst_at >= 0 && !tx_abort && k == tx_ack + rst_at) begin
        reset_n = 1'b0;
        #1;
        chk("arst_dtack_n", 16'(cpu_dtack_n), 16'h0001);
        chk("arst_din", cpu_din, 16'h0000);
        chk("arst_rd_req", 16'(src_rd_req), 16'h0000);
        chk("arst_wr_stb", 16'(src_wr_stb), 16'h0000);
        chk("arst_terr", 16'(timeout_err), 16'h0000);
        chk("arst_busy", 16'(busy), 16'h0000);
        tx_valid  = 0;
        cpu_as_n  = 1'b1;
        cpu_uds_n = 1'b1;
        cpu_lds_n = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        return;
      end
      if (k == tx_end - 1) begin
        cpu_as_n  = 1'b1;
        cpu_uds_n = 1'b1;
        cpu_lds_n = 1'b1;
      end
    end
    repeat (gap) begin
      @(negedge clk);
      src_ready = 8'h00;
      src_sel   = 8'($urandom);
    end
  endtask

  initial begin
    logic [127:0] d;
    reset_n = 1'b0; cpu_as_n = 1'b1; cpu_rw = 1'b1; cpu_uds_n = 1'b1; cpu_lds_n = 1'b1;
    src_sel = 8'h00; src_ready = 8'h00; src_dout = '0;
    repeat (3) @(negedge clk);
    chk("rst_dtack_n", 16'(cpu_dtack_n), 16'h0001);
    chk("rst_din", cpu_din, 16'h0000);
    chk("rst_busy", 16'(busy), 16'h0000);
    chk("rst_terr", 16'(timeout_err), 16'h0000);
    reset_n = 1'b1;

    // Fixed-source read from region 1.
    d = '0;
    d[31:16] = 16'hBEEF;
    run_tx(8'h02, 1, 1'b0, 1'b0, 0, 0, 1, 1, d, -1);
    chk("fix_latency", 16'(first_dt), 16'd2);
    chk("fix_din", cpu_din, 16'hBEEF);

    // Handshake ROM read, ready seen on the 7th edge after capture.
    d[15:0] = 16'h4E71;
    run_tx(8'h01, 1, 1'b0, 1'b0, 7, 0, 0, 1, d, -1);
    chk("hs_latency", 16'(first_dt), 16'd7);
    chk("hs_req_cycles", 16'(req_cycles), 16'd7);
    chk("hs_din", cpu_din, 16'h4E71);

    // Lower-byte write to region 4.
    run_tx(8'h10, 0, 1'b1, 1'b0, 0, 0, 1, 1, d, -1);
    chk("wr_stb_count", 16'(stb_cycles), 16'd1);
    chk("wr_stb_edge", 16'(stb_k), 16'd2);
    chk("wr_din_held", cpu_din, 16'h4E71);

    // Unmapped read.
    run_tx(8'h00, 1, 1'b0, 1'b0, 0, 0, 0, 1, d, -1);
    chk("unm_latency", 16'(first_dt), 16'd2);
    chk("unm_din", cpu_din, 16'hFFFF);
    chk("unm_terr", 16'(timeout_err), 16'h0000);

    // AS low with both strobes high must not start a cycle.
    @(negedge clk);
    tx_valid = 0;
    src_sel = 8'h02; cpu_rw = 1'b1; cpu_uds_n = 1'b1; cpu_lds_n = 1'b1; cpu_as_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rmw_busy", 16'(busy), 16'h0000);
    chk("rmw_dtack_n", 16'(cpu_dtack_n), 16'h0001);
    cpu_as_n = 1'b1;

    // Hung handshake source.
    run_tx(8'h01, 1, 1'b0, 1'b0, 0, 0, 0, 1, d, -1);
    chk("hung_latency", 16'(first_dt), 16'd256);
    chk("hung_din", cpu_din, 16'hFFFF);
    chk("hung_terr", 16'(timeout_err), 16'h0001);

    d[47:32] = 16'h1234;
    run_tx(8'h04, 1, 1'b0, 1'b0, 0, 0, 0, 1, d, -1);
    chk("after_hung_din", cpu_din, 16'h1234);
    chk("terr_sticky", 16'(timeout_err), 16'h0001);

    // Aborted cycle: AS rises on the first WAIT edge.
    run_tx(8'h02, 1, 1'b0, 1'b0, 0, 1, 0, 1, d, -1);
    chk("abort_no_dtack", 16'(first_dt), 16'hFFFF);
    chk("abort_busy", 16'(busy), 16'h0000);
    chk("abort_din", cpu_din, 16'h1234);

    // Reset one cycle into ACK.
    run_tx(8'h02, 1, 1'b0, 1'b0, 0, 0, 3, 1, d, 1);
    @(negedge clk);
    chk("post_rst_terr", 16'(timeout_err), 16'h0000);

    repeat (80) begin
      logic [7:0] sel;
      int s;
      sel = 8'($urandom);
      if ($urandom % 8 == 0) sel = 8'h00;
      s = $urandom % 3;
      d = {$urandom, $urandom, $urandom, $urandom};
      run_tx(sel, 1'($urandom % 2), 1'(s == 1), 1'(s == 2),
             ($urandom % 25 == 0) ? 0 : 1 + int'($urandom % 12),
             ($urandom % 6 == 0) ? 1 + int'($urandom % 14) : 0,
             int'($urandom % 4), int'($urandom % 3), d, -1);
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
